btb_train_sched: RTL
====================

Name: btb_train_sched

Overview:
Commit-side training scheduler for the branch target buffer.
- Accepts up to SIMBRCOM resolved-branch commits per cycle into an in-order queue.
- Drains the queue one entry per cycle onto the BTB's single write port.
- Sequences full-table clear walks after reset and on pipeline-requested flush.
- Gates fetch-side lookups (btb_ready) while a clear walk is in progress.

Parameters:
ADDR, 32, address width
BTB_D, 32, BTB entries (power of 2)
SIMBRCOM, 2, commits accepted per cycle
QDEPTH, 4, training queue depth (power of 2, >= SIMBRCOM)

Ports:
clk  in  1  clock
reset_  in  1  asynchronous active-low reset
pc_chg_com_  in  SIMBRCOM  active-low per-slot commit valid
chg_taken_  in  SIMBRCOM  active-low per-slot taken
com_addr  in  SIMBRCOM*ADDR  branch PC per slot
com_tar_addr  in  SIMBRCOM*ADDR  resolved target per slot
flush_  in  1  active-low request to clear the whole BTB
com_stall  out  1  high: commits this cycle are not accepted
btb_we_  out  1  active-low BTB write strobe
btb_clr_  out  1  active-low: write at btb_wr_idx is an invalidate
btb_wr_idx  out  $clog2(BTB_D)  entry index, = addr[IDXW+1:2] for training
btb_wr_taken_  out  1  active-low taken for counter update
btb_wr_addr  out  ADDR  branch PC (tag source)
btb_wr_tar  out  ADDR  target to store
btb_ready  out  1  high: BTB contents are valid for prediction

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
- Reset values:
  - State = INIT, walk_idx = 0, queue empty.
  - btb_we_ = 1, btb_clr_ = 1, btb_ready = 0, com_stall = 1.
  - btb_wr_* = 0.
- FSM states INIT, RUN and FLUSH. All BTB-port outputs are registered.
- INIT and FLUSH clear walk:
  - Each cycle drive btb_we_ = 0, btb_clr_ = 0, btb_wr_idx = walk_idx, then walk_idx += 1.
  - After index BTB_D-1 is issued, go to RUN.
  - The walk takes exactly BTB_D write cycles. btb_ready rises the cycle after the last clear.
- RUN:
  - btb_ready = 1.
  - If the queue is non-empty, pop the head. Next cycle drive btb_we_ = 0, btb_clr_ = 1, and idx/taken/addr/tar from that entry.
  - Otherwise btb_we_ = 1.
- Commit acceptance:
  - com_stall = 1 when state != RUN or free slots < SIMBRCOM. It is computed from registered state and count only.
  - When com_stall = 0, every slot with pc_chg_com_ = 0 is pushed in ascending slot order in one cycle.
  - Slots with pc_chg_com_ = 1 are skipped, so pushed entries are packed.
  - When com_stall = 1, inputs are ignored. The producer must hold them.
- Latency: a commit accepted at edge N appears on the BTB port with btb_we_ low in cycle N+1 when the queue was empty.
- Simultaneous push and pop:
  - Allowed in the same cycle.
  - count_next = count + pushes - pop.
  - Never exceeds QDEPTH because of the stall rule.
- Pointer wrap: read and write pointers are $clog2(QDEPTH) bits and wrap modulo QDEPTH. Full and empty are distinguished by a separate count register of width $clog2(QDEPTH)+1.
- flush_ = 0 in any state:
  - Next cycle: state = FLUSH, walk_idx = 0, queue emptied, btb_ready = 0.
  - Commits arriving in the same cycle are dropped.
  - flush_ during INIT or FLUSH restarts the walk at index 0.
  - flush_ held low keeps restarting, so the walk completes only after flush_ deasserts.
- Reset mid-walk or mid-drain: asynchronous return to the reset values; the walk restarts from 0.
- Duplicate PCs in the queue are not merged; they are written in order, and the later write wins.

Decomposition:
- Shared package or cpu_config.vh:
  - BtbState_t enum (INIT, RUN, FLUSH).
  - BtbTrainEnt_t struct {taken_, addr, tar}.
  - BtbIdxW = $clog2(BTB_D).
  - `BtbTrainQDepth default.
- One sub-module: btb_train_fifo, a parameterized multi-push (SIMBRCOM) / single-pop in-order queue with count output. The FSM and port driver stay in btb_train_sched.

Test Plan:
- Reset release, BTB_D = 32:
  - btb_we_ = 0 and btb_clr_ = 0 for exactly 32 cycles, idx 0..31.
  - com_stall = 1 throughout; btb_ready rises on cycle 33.
- RUN, two slots in one cycle:
  - Slot 0: taken, 0xdeadbe74 -> 0xcafecafe. Slot 1: not taken, 0xdeadbe18 -> 0xfffecafe.
  - Next cycle: write idx 0x1d, taken_ = 0, tar = 0xcafecafe.
  - The cycle after: idx 0x06, taken_ = 1, tar = 0xfffecafe. Then btb_we_ = 1.
- Queue fill (QDEPTH 4, SIMBRCOM 2):
  - Two-slot commits on 3 consecutive cycles.
  - com_stall = 1 once count reaches 3. The held third pair is accepted when count drops to 2.
  - All 6 writes emerge in order.
- Sparse slots: only slot 1 valid (pc 0x100) -> a single write with idx 0 and addr 0x100; no phantom write from slot 0.
- Flush with 3 queued entries:
  - flush_ low for 1 cycle -> queue discarded (no training writes), 32 clear writes.
  - btb_ready low for 33 cycles. A commit presented alongside flush_ is never written.
- Flush at walk index 10 during INIT -> walk restarts at 0 and completes 32 clears after flush_ deasserts.
- Async reset mid-drain -> outputs return to reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/btb_train_sched_pkg.sv
// Shared types and defaults for the BTB commit-side training scheduler.
package btb_train_sched_pkg;

  localparam int BtbAddrW       = 32;
  localparam int BtbDepth       = 32;
  localparam int BtbIdxW        = $clog2(BtbDepth);
  localparam int BtbSimBrCom    = 2;
  localparam int BtbTrainQDepth = 4;

  // Scheduler phases: INIT after reset, RUN while training, FLUSH on request.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } BtbState_t;

  // One training queue entry. The queue stores this layout as a flat vector
  // {taken_, addr, tar} so the address width can follow the top parameter.
  typedef struct packed {
    logic                taken_;
    logic [BtbAddrW-1:0] addr;
    logic [BtbAddrW-1:0] tar;
  } BtbTrainEnt_t;

endpackage

// File: rtl/btb_train_fifo.sv
// In-order queue: up to NPUSH packed pushes and one pop per cycle.
// Pointers wrap modulo DEPTH; a separate count tells full from empty.
module btb_train_fifo #(
  parameter int W     = 65,
  parameter int NPUSH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_en_i,
  input  logic [NPUSH-1:0]           push_vld_i,
  input  logic [NPUSH*W-1:0]         push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] slot_pos [NPUSH];
  logic [CW-1:0] n_push;
  logic          pop_ok;

  // Valid slots land at consecutive positions so pushed entries stay packed.
  always_comb begin
    n_push = '0;
    for (int s = 0; s < NPUSH; s++) begin
      slot_pos[s] = wr_q + n_push[PW-1:0];
      if (push_en_i && push_vld_i[s]) begin
        n_push = n_push + CW'(1);
      end
    end
  end

  assign pop_ok = pop_i && (cnt_q != '0);

  // Pointer and occupancy update; clear wins over any push or pop.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + n_push[PW-1:0];
      if (pop_ok) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + n_push - CW'(pop_ok);
    end
  end

  // Storage array; contents need no reset since count gates their use.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NPUSH; s++) begin
      if (push_en_i && push_vld_i[s] && !clr_i) begin
        mem_q[slot_pos[s]] <= push_data_i[s*W +: W];
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/btb_train_sched.sv
// BTB training scheduler: queues resolved-branch commits, drains one per
// cycle onto the BTB write port, and runs full-table clear walks after reset
// and on flush requests.
module btb_train_sched
  import btb_train_sched_pkg::*;
#(
  parameter int ADDR     = BtbAddrW,
  parameter int BTB_D    = BtbDepth,
  parameter int SIMBRCOM = BtbSimBrCom,
  parameter int QDEPTH   = BtbTrainQDepth
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic [SIMBRCOM-1:0]        pc_chg_com_,
  input  logic [SIMBRCOM-1:0]        chg_taken_,
  input  logic [SIMBRCOM*ADDR-1:0]   com_addr,
  input  logic [SIMBRCOM*ADDR-1:0]   com_tar_addr,
  input  logic                       flush_,
  output logic                       com_stall,
  output logic                       btb_we_,
  output logic                       btb_clr_,
  output logic [$clog2(BTB_D)-1:0]   btb_wr_idx,
  output logic                       btb_wr_taken_,
  output logic [ADDR-1:0]            btb_wr_addr,
  output logic [ADDR-1:0]            btb_wr_tar,
  output logic                       btb_ready
);

  localparam int IDXW = $clog2(BTB_D);
  localparam int EW   = 1 + 2*ADDR;
  localparam int CW   = $clog2(QDEPTH) + 1;

  BtbState_t              state_q;
  logic [IDXW-1:0]        walk_q;
  logic                   we_q;
  logic                   clr_q;
  logic                   ready_q;
  logic [IDXW-1:0]        idx_q;
  logic                   taken_q;
  logic [ADDR-1:0]        addr_q;
  logic [ADDR-1:0]        tar_q;

  logic [SIMBRCOM*EW-1:0] push_data;
  logic [EW-1:0]          head;
  logic [CW-1:0]          count;
  logic                   stall;
  logic                   push_en;
  logic                   pop;

  // Pack each slot as {taken_, addr, tar}, matching BtbTrainEnt_t.
  for (genvar gi = 0; gi < SIMBRCOM; gi++) begin : g_pack
    assign push_data[gi*EW +: EW] = {chg_taken_[gi],
                                     com_addr[gi*ADDR +: ADDR],
                                     com_tar_addr[gi*ADDR +: ADDR]};
  end

  // Stall depends only on registered state so the producer sees it early.
  assign stall   = (state_q != RUN) || (count > CW'(QDEPTH - SIMBRCOM));
  assign push_en = !stall && flush_;
  assign pop     = (state_q == RUN) && (count != '0) && flush_;

  btb_train_fifo #(
    .W     (EW),
    .NPUSH (SIMBRCOM),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (reset_),
    .clr_i       (!flush_),
    .push_en_i   (push_en),
    .push_vld_i  (~pc_chg_com_),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  // Phase FSM with registered BTB port: clear walk, then one training write per cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= INIT;
      walk_q  <= '0;
      we_q    <= 1'b1;
      clr_q   <= 1'b1;
      ready_q <= 1'b0;
      idx_q   <= '0;
      taken_q <= 1'b0;
      addr_q  <= '0;
      tar_q   <= '0;
    end else if (!flush_) begin
      // Any flush request restarts the walk; queued work is discarded.
      state_q <= FLUSH;
      walk_q  <= '0;
      we_q    <= 1'b1;
      clr_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT, FLUSH: begin
          we_q    <= 1'b0;
          clr_q   <= 1'b0;
          idx_q   <= walk_q;
          walk_q  <= walk_q + IDXW'(1);
          ready_q <= 1'b0;
          if (walk_q == IDXW'(BTB_D - 1)) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
          clr_q   <= 1'b1;
          if (pop) begin
            we_q    <= 1'b0;
            taken_q <= head[EW-1];
            addr_q  <= head[2*ADDR-1:ADDR];
            tar_q   <= head[ADDR-1:0];
            idx_q   <= head[ADDR+IDXW+1:ADDR+2];
          end else begin
            we_q <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
          walk_q  <= '0;
        end
      endcase
    end
  end

  assign com_stall     = stall;
  assign btb_we_       = we_q;
  assign btb_clr_      = clr_q;
  assign btb_wr_idx    = idx_q;
  assign btb_wr_taken_ = taken_q;
  assign btb_wr_addr   = addr_q;
  assign btb_wr_tar    = tar_q;
  assign btb_ready     = ready_q;

endmodule
